// File: rtl/voice_allocator.sv
// Note-event scheduler for a bank of envelope_generator voices: picks a free voice per note-on
// and issues 1-cycle note_on/note_off pulses. Define VOICE_STEAL_EN to steal the oldest voice when none is free.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7,
  parameter int AGE_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        ev_valid,
  output logic                        ev_ready,
  input  logic                        ev_on,
  input  logic [KEY_W-1:0]            ev_key,
  input  logic [NUM_VOICES-1:0]       voice_busy,
  input  logic [NUM_VOICES-1:0]       voice_done,
  output logic [NUM_VOICES-1:0]       voice_note_on,
  output logic [NUM_VOICES-1:0]       voice_note_off,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [15:0]                 drop_cnt
);

  localparam int IW = $clog2(NUM_VOICES);

  typedef enum logic [2:0] {
    S_IDLE, S_PROC, S_PULSE, S_STEAL_OFF, S_STEAL_WAIT
  } state_t;

  state_t                             r_state;
  logic                               r_ev_on;
  logic [KEY_W-1:0]                   r_ev_key;
  logic [NUM_VOICES-1:0]              r_alloc;
  logic [NUM_VOICES-1:0]              r_held;
  logic [NUM_VOICES-1:0]              r_note_on;
  logic [NUM_VOICES-1:0]              r_note_off;
  logic [NUM_VOICES-1:0][KEY_W-1:0]   r_voice_key;
  logic [AGE_W-1:0]                   r_age [NUM_VOICES];
  logic [15:0]                        r_drop_cnt;

  logic                               w_match;
  logic                               w_free_found;
  logic [IW-1:0]                      w_off_idx;
  logic [IW-1:0]                      w_free_idx;
  logic [IW-1:0]                      w_alloc_idx;
  logic                               w_do_alloc;
  logic [NUM_VOICES-1:0]              w_done_mask;

`ifdef VOICE_STEAL_EN
  logic [IW-1:0]                      r_victim;
  logic [IW-1:0]                      w_vic_idx;
  logic [AGE_W-1:0]                   w_vic_age;
  logic                               w_steal_alloc;
`endif

  assign ev_ready       = (r_state == S_IDLE);
  assign voice_note_on  = r_note_on;
  assign voice_note_off = r_note_off;
  assign voice_key      = r_voice_key;
  assign drop_cnt       = r_drop_cnt;

  // Lowest-index searches; strict '>' on age keeps ties at the lowest index.
  always_comb begin
    w_match      = 1'b0;
    w_off_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
`ifdef VOICE_STEAL_EN
    w_vic_idx    = '0;
    w_vic_age    = '0;
`endif
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!w_match && r_held[i] && (r_voice_key[i] == r_ev_key)) begin
        w_match   = 1'b1;
        w_off_idx = IW'(i);
      end
      if (!w_free_found && !r_alloc[i] && !voice_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
`ifdef VOICE_STEAL_EN
      if (r_age[i] > w_vic_age) begin
        w_vic_age = r_age[i];
        w_vic_idx = IW'(i);
      end
`endif
    end
  end

  // A steal completes on the same edge that consumes the victim's done, so the
  // victim's new allocation must override that done-driven release.
  always_comb begin
    w_alloc_idx = w_free_idx;
    w_do_alloc  = (r_state == S_PROC) && r_ev_on && !w_match && w_free_found;
    w_done_mask = voice_done;
`ifdef VOICE_STEAL_EN
    w_steal_alloc = ((r_state == S_STEAL_OFF) || (r_state == S_STEAL_WAIT)) && voice_done[r_victim];
    if (w_steal_alloc) begin
      w_alloc_idx            = r_victim;
      w_do_alloc             = 1'b1;
      w_done_mask[r_victim]  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_ev_on     <= 1'b0;
      r_ev_key    <= '0;
      r_alloc     <= '0;
      r_held      <= '0;
      r_note_on   <= '0;
      r_note_off  <= '0;
      r_voice_key <= '0;
      r_drop_cnt  <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
`ifdef VOICE_STEAL_EN
      r_victim    <= '0;
`endif
    end else begin
      r_note_on  <= '0;
      r_note_off <= '0;

      if (w_do_alloc) begin
        r_note_on[w_alloc_idx]   <= 1'b1;
        r_alloc[w_alloc_idx]     <= 1'b1;
        r_held[w_alloc_idx]      <= 1'b1;
        r_voice_key[w_alloc_idx] <= r_ev_key;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (IW'(i) == w_alloc_idx)              r_age[i] <= '0;
          else if (r_alloc[i] && (r_age[i] != '1)) r_age[i] <= r_age[i] + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (ev_valid) begin
            r_ev_on  <= ev_on;
            r_ev_key <= ev_key;
            r_state  <= S_PROC;
          end
        end
        S_PROC: begin
          r_state <= S_IDLE;
          if (r_ev_on) begin
            if (!w_match) begin
              if (w_free_found) begin
                r_state <= S_PULSE;
              end else begin
`ifdef VOICE_STEAL_EN
                r_victim <= w_vic_idx;
                if (r_held[w_vic_idx]) begin
                  r_note_off[w_vic_idx] <= 1'b1;
                  r_held[w_vic_idx]     <= 1'b0;
                  r_state               <= S_STEAL_OFF;
                end else begin
                  r_state <= S_STEAL_WAIT;
                end
`else
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
`endif
              end
            end
          end else if (w_match) begin
            r_note_off[w_off_idx] <= 1'b1;
            r_held[w_off_idx]     <= 1'b0;
            r_state               <= S_PULSE;
          end
        end
        S_PULSE: r_state <= S_IDLE;
`ifdef VOICE_STEAL_EN
        S_STEAL_OFF, S_STEAL_WAIT: begin
          if (voice_done[r_victim]) r_state <= S_PULSE;
          else                      r_state <= S_STEAL_WAIT;
        end
`endif
        default: r_state <= S_IDLE;
      endcase

      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (w_done_mask[i]) begin
          r_alloc[i] <= 1'b0;
          r_held[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int KW = 7;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [KW-1:0]     ev_key;
  logic [NV-1:0]     voice_busy;
  logic [NV-1:0]     voice_done;
  logic [NV-1:0]     voice_note_on;
  logic [NV-1:0]     voice_note_off;
  logic [NV*KW-1:0]  voice_key;
  logic [15:0]       drop_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NV-1:0] on;
    logic [NV-1:0] off;
    int            vidx;
    logic [KW-1:0] key;
  } exp_t;
  exp_t exp_q[$];

  voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(8)) dut (
    .clk(clk), .rst_b(rst_b), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_key(ev_key), .voice_busy(voice_busy), .voice_done(voice_done),
    .voice_note_on(voice_note_on), .voice_note_off(voice_note_off),
    .voice_key(voice_key), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [NV-1:0] on, input logic [NV-1:0] off, input int vidx, input logic [KW-1:0] key);
    exp_t e;
    e.on = on; e.off = off; e.vidx = vidx; e.key = key;
    exp_q.push_back(e);
  endtask

  // Drive at a negedge; returns #1 after the accepting posedge.
  task automatic send(input logic on, input logic [KW-1:0] key);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = key;
    @(posedge clk);
    #1 ev_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ev_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, ev_ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_b && ((voice_note_on | voice_note_off) != '0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: on=%b off=%b expected none", voice_note_on, voice_note_off);
      end else begin
        exp_t e;
        logic [KW-1:0] k;
        e = exp_q.pop_front();
        k = voice_key[e.vidx*KW +: KW];
        if (voice_note_on !== e.on || voice_note_off !== e.off || k !== e.key) begin
          failures++;
          $display("FAIL pulse: on=%b off=%b key[%0d]=%0d expected on=%b off=%b key=%0d",
                   voice_note_on, voice_note_off, e.vidx, k, e.on, e.off, e.key);
        end
      end
    end
  end

  initial begin
    rst_b = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_key = '0;
    voice_busy = '0; voice_done = '0;
    repeat (3) @(negedge clk);
    chk("rst_note_on",  {28'd0, voice_note_on}, 32'd0);
    chk("rst_note_off", {28'd0, voice_note_off}, 32'd0);
    chk("rst_drop",     {16'd0, drop_cnt}, 32'd0);
    chk("rst_ready",    {31'd0, ev_ready}, 32'd1);
    rst_b = 1'b1;
    @(negedge clk);

    // Reset asserted while a note_on pulse is live.
    send(1'b1, 7'd10);
    @(posedge clk);
    #1 chk("pre_reset_pulse", {28'd0, voice_note_on}, 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    chk("midrst_note_on", {28'd0, voice_note_on}, 32'd0);
    chk("midrst_key",     voice_key, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'd0, ev_ready}, 32'd1);

    // First note-on with exact latency checks.
    push(4'b0001, 4'b0000, 0, 7'd60);
    send(1'b1, 7'd60);
    chk("proc_ready_low", {31'd0, ev_ready}, 32'd0);
    @(negedge clk);
    chk("proc_no_pulse", {28'd0, voice_note_on}, 32'd0);
    @(negedge clk);
    chk("t2_pulse", {28'd0, voice_note_on}, 32'd1);
    chk("t2_ready_low", {31'd0, ev_ready}, 32'd0);
    @(negedge clk);
    chk("t3_ready", {31'd0, ev_ready}, 32'd1);
    chk("t3_pulse_gone", {28'd0, voice_note_on}, 32'd0);

    push(4'b0010, 4'b0000, 1, 7'd64);
    send(1'b1, 7'd64); wait_ready();

    push(4'b0000, 4'b0010, 1, 7'd64);
    send(1'b0, 7'd64); wait_ready();
    send(1'b0, 7'd64); wait_ready();          // duplicate note-off: no pulse

    voice_done = 4'b0010;
    @(negedge clk);
    voice_done = '0;

    send(1'b1, 7'd60); wait_ready();          // key 60 still held: ignored
    chk("dup_on_drop", {16'd0, drop_cnt}, 32'd0);

    push(4'b0010, 4'b0000, 1, 7'd61);         // released voice 1 reused
    send(1'b1, 7'd61); wait_ready();

    voice_busy = 4'b0100;                     // voice 2 busy though unowned
    push(4'b1000, 4'b0000, 3, 7'd62);
    send(1'b1, 7'd62); wait_ready();
    voice_busy = '0;

    push(4'b0100, 4'b0000, 2, 7'd63);
    send(1'b1, 7'd63); wait_ready();
    chk("all_keys", voice_key, {4'd0, 7'd62, 7'd63, 7'd61, 7'd60});

`ifdef VOICE_STEAL_EN
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      push(NV'(1 << i), 4'b0000, i, KW'(60 + i));
      send(1'b1, KW'(60 + i)); wait_ready();
    end
    push(4'b0000, 4'b0001, 0, 7'd60);
    push(4'b0001, 4'b0000, 0, 7'd70);
    send(1'b1, 7'd70);
    begin
      int hi = 0;
      repeat (20) begin
        @(negedge clk);
        if (ev_ready) hi++;
      end
      chk("steal_ready_low", hi, 32'd0);
    end
    voice_done = 4'b0001;
    @(negedge clk);
    voice_done = '0;
    wait_ready();
    chk("steal_key0", {25'd0, voice_key[KW-1:0]}, 32'd70);
    chk("steal_drop", {16'd0, drop_cnt}, 32'd0);
`else
    send(1'b1, 7'd65); wait_ready();          // no free voice: dropped
    chk("drop_1", {16'd0, drop_cnt}, 32'd1);
    push(4'b0000, 4'b1000, 3, 7'd62);
    send(1'b0, 7'd62); wait_ready();
    send(1'b1, 7'd66); wait_ready();          // voice 3 still owned until done
    chk("drop_2", {16'd0, drop_cnt}, 32'd2);
    chk("keys_retained", voice_key, {4'd0, 7'd62, 7'd63, 7'd61, 7'd60});
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules note events onto a bank of NUM_VOICES envelope_generator instances.
- Accepts note-on/off events over a valid/ready handshake and picks a free voice for each note-on.
- Issues one-cycle note_on/note_off pulses to the voices and tracks per-voice ownership from each voice's busy/done outputs.
- Sits between the key/event front end and the envelope generator bank.

Parameters:
- NUM_VOICES, 4, number of envelope generator voices driven (2..16).
- KEY_W, 7, width of note key number.
- AGE_W, 8, width of per-voice saturating age counter.

Ports:
- clk  input  1  system clock
- rst_b  input  1  asynchronous active-low reset
- ev_valid  input  1  event present
- ev_ready  output  1  block can accept an event
- ev_on  input  1  1 = note-on, 0 = note-off
- ev_key  input  KEY_W  key number of event
- voice_busy  input  NUM_VOICES  busy output of each voice
- voice_done  input  NUM_VOICES  done output of each voice (1-cycle, end of release)
- voice_note_on  output  NUM_VOICES  1-cycle note_on pulse per voice
- voice_note_off  output  NUM_VOICES  1-cycle note_off pulse per voice
- voice_key  output  NUM_VOICES*KEY_W  key owned by voice i at bits [i*KEY_W +: KEY_W]
- drop_cnt  output  16  count of dropped note-ons, saturating at 16'hFFFF

Behaviour:
- Reset values: single clock clk; asynchronous active-low reset rst_b.
  - On reset: all pulses 0, voice_key 0, drop_cnt 0, alloc/held/age cleared, state IDLE.
  - Reset mid-operation aborts any pending pulse or steal.
- Per-voice registers:
  - alloc[i]: voice owned.
  - held[i]: note-off not yet sent.
  - age[i]: AGE_W bits.
- Free voice: !alloc[i] && !voice_busy[i].
- Handshake: ev_ready = (state==IDLE), combinational from state. Event accepted on a clk edge with ev_valid && ev_ready; ev_on/ev_key are latched at that edge.
- State machine:
  - IDLE -> PROC on accept.
  - PROC (1 cycle) searches using registered alloc/held/age/busy:
    - Note-on, key already held by a voice: ignored, -> IDLE, no pulse.
    - Note-on, free voice exists: lowest-index free voice v.
      - At the PROC->PULSE edge: voice_note_on[v]=1, alloc[v]=1, held[v]=1, voice_key[v]=key, age[v]=0.
      - Every other alloc voice's age increments, saturating at all-ones.
      - -> PULSE.
    - Note-on, no free voice: drop_cnt++ (saturating), -> IDLE.
    - Note-off, held voice with matching key: lowest such index v. voice_note_off[v]=1, held[v]=0, -> PULSE.
    - Note-off, no match: ignored, -> IDLE.
  - PULSE (1 cycle): pulse visible for exactly this cycle, ev_ready=0, -> IDLE.
  - Event latency: accept edge T, pulse high in cycle T+2, ev_ready high again in cycle T+3. Max throughput is one event per 3 cycles.
- Ownership release: voice_done[i] clears alloc[i] and held[i] at the next edge. This takes priority over any set to the same voice in that cycle (cannot occur for a free voice).
- voice_key[i] retains its last value after release.
- Pulses are never asserted to more than one voice per cycle, and never note_on and note_off together.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Without it: no free voice -> note-on dropped, drop_cnt++ as above.
- With it: no free voice -> steal victim v = voice with largest age, ties to lowest index.
  - If held[v]: voice_note_off[v] pulses in STEAL_OFF (1 cycle), held[v]=0.
  - Then STEAL_WAIT until voice_done[v]==1. ev_ready stays 0 throughout.
  - The edge after done is seen: PULSE with voice_note_on[v]=1, voice_key[v]=new key, alloc/held set, age reset.
  - drop_cnt is never incremented in this build.
  - A reset during STEAL_WAIT abandons the steal.

Test Plan:
- Reset: hold rst_b=0 mid-pulse -> all voice_note_on/off 0, drop_cnt 0, ev_ready 1 after release.
- Note-on key 60, all voices idle -> voice_note_on=4'b0001 in cycle T+2 only, voice_key[0]=60. Second note-on key 64 -> 4'b0010.
- Note-off key 64 with voices 0/1 holding 60/64 -> voice_note_off=4'b0010 once. Duplicate note-off 64 -> no pulse. voice_done[1] -> voice 1 reusable by the next note-on.
- Duplicate note-on key 60 while held -> no pulse, no drop_cnt change.
- Five note-ons (keys 60..64) with NUM_VOICES=4, no steal -> fifth gives no pulse, drop_cnt=1.
- VOICE_STEAL_EN, voices 0..3 allocated in order, fifth note-on key 70 -> note_off pulse on voice 0, ev_ready low until voice_done[0] asserted 20 cycles later, then note_on on voice 0 with voice_key[0]=70.
